// File: rtl/pico_axi_rdata_downsizer_pkg.sv
// Shared AXI definitions for the pico AXI upsizer/downsizer bridge pair.
package pico_axi_rdata_downsizer_pkg;

   localparam int unsigned AXI_RESP_W = 2;
   localparam int unsigned AXI_LEN_W  = 8;
   localparam int unsigned AXI_SIZE_W = 3;

   localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [AXI_RESP_W-1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

   // Minimum result is 1 so a counter sized by it never collapses to zero width.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((32'd1 << res) < value) res++;
      return (res == 0) ? 1 : res;
   endfunction

endpackage

// File: rtl/pico_axi_reg_slice.sv
// One-entry valid/ready register slice; accepts a new word in the same cycle the held one drains.
module pico_axi_reg_slice #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   assign ready_o = ~valid_q | ready_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (valid_i && ready_o) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/pico_axi_rdata_downsizer.sv
// Serializes wide R beats into UPSIZE_RATIO narrow beats (LSB slice first); B passes through a register slice.
module pico_axi_rdata_downsizer
   import pico_axi_rdata_downsizer_pkg::*;
#(
   parameter int unsigned C_AXI_ID_WIDTH         = 8,
   parameter int unsigned C_AXI_SLAVE_DATA_WIDTH = 128,
   parameter int unsigned UPSIZE_RATIO           = 2,
   parameter int unsigned LOG_UPSIZE_RATIO       = 1
) (
   input  logic                                           aclk,
   input  logic                                           aresetn,
   input  logic                                           m_axi_rvalid,
   output logic                                           m_axi_rready,
   input  logic [C_AXI_ID_WIDTH-1:0]                      m_axi_rid,
   input  logic [UPSIZE_RATIO*C_AXI_SLAVE_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [AXI_RESP_W-1:0]                          m_axi_rresp,
   input  logic                                           m_axi_rlast,
   output logic                                           s_axi_rvalid,
   input  logic                                           s_axi_rready,
   output logic [C_AXI_ID_WIDTH-1:0]                      s_axi_rid,
   output logic [C_AXI_SLAVE_DATA_WIDTH-1:0]              s_axi_rdata,
   output logic [AXI_RESP_W-1:0]                          s_axi_rresp,
   output logic                                           s_axi_rlast,
   input  logic                                           m_axi_bvalid,
   output logic                                           m_axi_bready,
   input  logic [C_AXI_ID_WIDTH-1:0]                      m_axi_bid,
   input  logic [AXI_RESP_W-1:0]                          m_axi_bresp,
   output logic                                           s_axi_bvalid,
   input  logic                                           s_axi_bready,
   output logic [C_AXI_ID_WIDTH-1:0]                      s_axi_bid,
   output logic [AXI_RESP_W-1:0]                          s_axi_bresp
);

   localparam int unsigned W = C_AXI_SLAVE_DATA_WIDTH;
   localparam int unsigned I = C_AXI_ID_WIDTH;

   generate
      if (UPSIZE_RATIO == 1) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = aclk ^ aresetn;

         assign s_axi_rvalid = m_axi_rvalid;
         assign m_axi_rready = s_axi_rready;
         assign s_axi_rid    = m_axi_rid;
         assign s_axi_rdata  = m_axi_rdata;
         assign s_axi_rresp  = m_axi_rresp;
         assign s_axi_rlast  = m_axi_rlast;
         assign s_axi_bvalid = m_axi_bvalid;
         assign m_axi_bready = s_axi_bready;
         assign s_axi_bid    = m_axi_bid;
         assign s_axi_bresp  = m_axi_bresp;
      end else begin : g_ser
         localparam logic [LOG_UPSIZE_RATIO-1:0] LAST_SEL = LOG_UPSIZE_RATIO'(UPSIZE_RATIO - 1);

         logic                        hold_valid_q, hold_valid_d;
         logic [LOG_UPSIZE_RATIO-1:0] sel_q, sel_d;
         logic [UPSIZE_RATIO*W-1:0]   hold_data_q, hold_data_d;
         logic [I-1:0]                hold_id_q, hold_id_d;
         logic [AXI_RESP_W-1:0]       hold_resp_q, hold_resp_d;
         logic                        hold_last_q, hold_last_d;
         logic                        take_m, give_s, final_slice;

         assign final_slice  = (sel_q == LAST_SEL);
         assign give_s       = hold_valid_q & s_axi_rready;
         // Refill in the cycle the final slice leaves so wide beats stream without a bubble.
         assign m_axi_rready = ~hold_valid_q | (give_s & final_slice);
         assign take_m       = m_axi_rvalid & m_axi_rready;

         assign s_axi_rvalid = hold_valid_q;
         assign s_axi_rdata  = hold_data_q[sel_q*W +: W];
         assign s_axi_rid    = hold_id_q;
         assign s_axi_rresp  = hold_resp_q;
         assign s_axi_rlast  = hold_last_q & final_slice;

         always_comb begin
            hold_valid_d = hold_valid_q;
            sel_d        = sel_q;
            hold_data_d  = hold_data_q;
            hold_id_d    = hold_id_q;
            hold_resp_d  = hold_resp_q;
            hold_last_d  = hold_last_q;
            if (take_m) begin
               hold_valid_d = 1'b1;
               sel_d        = '0;
               hold_data_d  = m_axi_rdata;
               hold_id_d    = m_axi_rid;
               hold_resp_d  = m_axi_rresp;
               hold_last_d  = m_axi_rlast;
            end else if (give_s) begin
               if (final_slice) begin
                  hold_valid_d = 1'b0;
                  sel_d        = '0;
               end else begin
                  sel_d = sel_q + 1'b1;
               end
            end
         end

         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               hold_valid_q <= 1'b0;
               sel_q        <= '0;
               hold_data_q  <= '0;
               hold_id_q    <= '0;
               hold_resp_q  <= '0;
               hold_last_q  <= 1'b0;
            end else begin
               hold_valid_q <= hold_valid_d;
               sel_q        <= sel_d;
               hold_data_q  <= hold_data_d;
               hold_id_q    <= hold_id_d;
               hold_resp_q  <= hold_resp_d;
               hold_last_q  <= hold_last_d;
            end
         end

         pico_axi_reg_slice #(
            .WIDTH(I + AXI_RESP_W)
         ) u_b_slice (
            .clk_i  (aclk),
            .rst_ni (aresetn),
            .valid_i(m_axi_bvalid),
            .ready_o(m_axi_bready),
            .data_i ({m_axi_bid, m_axi_bresp}),
            .valid_o(s_axi_bvalid),
            .ready_i(s_axi_bready),
            .data_o ({s_axi_bid, s_axi_bresp})
         );
      end
   endgenerate

endmodule

// File: tb/tb_pico_axi_rdata_downsizer.sv
// Scoreboard bench for pico_axi_rdata_downsizer: random R/B traffic plus directed corner cases.
module tb_pico_axi_rdata_downsizer;
   import pico_axi_rdata_downsizer_pkg::*;

   localparam int I = 8;
   localparam int W = 128;
   localparam int R = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic           m_rvalid = 0, m_rready, m_rlast = 0;
   logic [I-1:0]   m_rid = '0;
   logic [R*W-1:0] m_rdata = '0;
   logic [1:0]     m_rresp = '0;
   logic           s_rvalid, s_rready = 0, s_rlast;
   logic [I-1:0]   s_rid;
   logic [W-1:0]   s_rdata;
   logic [1:0]     s_rresp;
   logic           m_bvalid = 0, m_bready, s_bvalid, s_bready = 0;
   logic [I-1:0]   m_bid = '0, s_bid;
   logic [1:0]     m_bresp = '0, s_bresp;

   pico_axi_rdata_downsizer #(
      .C_AXI_ID_WIDTH(I), .C_AXI_SLAVE_DATA_WIDTH(W), .UPSIZE_RATIO(R), .LOG_UPSIZE_RATIO(1)
   ) dut (
      .aclk(clk), .aresetn(rst_n),
      .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready), .m_axi_rid(m_rid),
      .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
      .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready), .s_axi_rid(s_rid),
      .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
      .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready), .m_axi_bid(m_bid), .m_axi_bresp(m_bresp),
      .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready), .s_axi_bid(s_bid), .s_axi_bresp(s_bresp)
   );

   // Ratio-1 build: expected to be a pure wire-through.
   logic         p_mrv = 0, p_mrr, p_mrl = 0, p_srv, p_srr = 0, p_srl;
   logic [I-1:0] p_mrid = '0, p_srid, p_mbid = '0, p_sbid;
   logic [W-1:0] p_mrd = '0, p_srd;
   logic [1:0]   p_mrs = '0, p_srs, p_mbs = '0, p_sbs;
   logic         p_mbv = 0, p_mbr, p_sbv, p_sbr = 0;

   pico_axi_rdata_downsizer #(
      .C_AXI_ID_WIDTH(I), .C_AXI_SLAVE_DATA_WIDTH(W), .UPSIZE_RATIO(1), .LOG_UPSIZE_RATIO(1)
   ) dut1 (
      .aclk(clk), .aresetn(rst_n),
      .m_axi_rvalid(p_mrv), .m_axi_rready(p_mrr), .m_axi_rid(p_mrid),
      .m_axi_rdata(p_mrd), .m_axi_rresp(p_mrs), .m_axi_rlast(p_mrl),
      .s_axi_rvalid(p_srv), .s_axi_rready(p_srr), .s_axi_rid(p_srid),
      .s_axi_rdata(p_srd), .s_axi_rresp(p_srs), .s_axi_rlast(p_srl),
      .m_axi_bvalid(p_mbv), .m_axi_bready(p_mbr), .m_axi_bid(p_mbid), .m_axi_bresp(p_mbs),
      .s_axi_bvalid(p_sbv), .s_axi_bready(p_sbr), .s_axi_bid(p_sbid), .s_axi_bresp(p_sbs)
   );

   typedef struct packed {
      logic [W-1:0] d;
      logic [I-1:0] id;
      logic [1:0]   resp;
      logic         last;
   } rbeat_t;
   typedef struct packed {
      logic [I-1:0] id;
      logic [1:0]   resp;
   } bbeat_t;

   rbeat_t rq[$];
   bbeat_t bq[$];
   int checks = 0;
   int errors = 0;
   bit rr_rand = 0, br_rand = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: a wide beat becomes R narrow beats, slice k = bits [k*W +: W], rlast only on the last slice.
   task automatic drive_r(input logic [R*W-1:0] d, input logic [I-1:0] id,
                          input logic [1:0] resp, input logic last);
      m_rvalid = 1; m_rdata = d; m_rid = id; m_rresp = resp; m_rlast = last;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (m_rready) begin
            for (int k = 0; k < R; k++)
               rq.push_back('{d: d[k*W +: W], id: id, resp: resp, last: last && (k == R-1)});
            @(posedge clk); #1;
            m_rvalid = 0;
            return;
         end
      end
      chk("r_accept_timeout", 0, 1);
      m_rvalid = 0;
   endtask

   task automatic drive_b(input logic [I-1:0] id, input logic [1:0] resp);
      m_bvalid = 1; m_bid = id; m_bresp = resp;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (m_bready) begin
            bq.push_back('{id: id, resp: resp});
            @(posedge clk); #1;
            m_bvalid = 0;
            return;
         end
      end
      chk("b_accept_timeout", 0, 1);
      m_bvalid = 0;
   endtask

   function automatic logic [R*W-1:0] rnd_wide();
      logic [R*W-1:0] v;
      for (int k = 0; k < R*W/32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // Monitor: pops the scoreboard on each narrow handshake and checks stall stability.
   bit     r_stall = 0, b_stall = 0;
   rbeat_t pr, er;
   bbeat_t pb, eb;
   always @(negedge clk) begin
      if (!rst_n) begin
         r_stall = 0;
         b_stall = 0;
      end else begin
         if (r_stall) begin
            chk("r_stall_valid", W'(s_rvalid), 1);
            chk("r_stall_data", s_rdata, pr.d);
            chk("r_stall_last", W'(s_rlast), W'(pr.last));
         end
         if (s_rvalid && s_rready) begin
            if (rq.size() == 0) chk("r_spurious", 1, 0);
            else begin
               er = rq.pop_front();
               chk("r_data", s_rdata, er.d);
               chk("r_id", W'(s_rid), W'(er.id));
               chk("r_resp", W'(s_rresp), W'(er.resp));
               chk("r_last", W'(s_rlast), W'(er.last));
            end
            r_stall = 0;
         end else if (s_rvalid) begin
            r_stall = 1;
            pr = '{d: s_rdata, id: s_rid, resp: s_rresp, last: s_rlast};
         end else r_stall = 0;

         if (b_stall) begin
            chk("b_stall_valid", W'(s_bvalid), 1);
            chk("b_stall_id", W'(s_bid), W'(pb.id));
         end
         if (s_bvalid && s_bready) begin
            if (bq.size() == 0) chk("b_spurious", 1, 0);
            else begin
               eb = bq.pop_front();
               chk("b_id", W'(s_bid), W'(eb.id));
               chk("b_resp", W'(s_bresp), W'(eb.resp));
            end
            b_stall = 0;
         end else if (s_bvalid) begin
            b_stall = 1;
            pb = '{id: s_bid, resp: s_bresp};
         end else b_stall = 0;
      end
   end

   initial begin : rready_gen
      forever begin
         @(posedge clk); #1;
         if (rr_rand) s_rready = 1'($urandom_range(0, 1));
         if (br_rand) s_bready = 1'($urandom_range(0, 1));
      end
   end

   task automatic wait_rvalid();
      for (int n = 0; n < 50; n++) begin
         if (s_rvalid) return;
         @(posedge clk); #1;
      end
      chk("rvalid_timeout", 0, 1);
   endtask

   task automatic drain();
      s_rready = 1; s_bready = 1;
      for (int n = 0; n < 500; n++) begin
         @(posedge clk); #1;
         if (rq.size() == 0 && bq.size() == 0 && !s_rvalid && !s_bvalid) break;
      end
      chk("drain_r_empty", W'(rq.size()), 0);
      chk("drain_b_empty", W'(bq.size()), 0);
   endtask

   initial begin
      #22;
      chk("rst_s_rvalid", W'(s_rvalid), 0);
      chk("rst_s_rlast", W'(s_rlast), 0);
      chk("rst_s_rdata", s_rdata, 0);
      chk("rst_s_rid", W'(s_rid), 0);
      chk("rst_m_rready", W'(m_rready), 1);
      chk("rst_s_bvalid", W'(s_bvalid), 0);
      chk("rst_m_bready", W'(m_bready), 1);
      rst_n = 1;
      @(posedge clk); #1;

      // Single wide beat: AAAA slice then BBBB slice.
      s_rready = 1;
      drive_r({{8{16'hBBBB}}, {8{16'hAAAA}}}, 8'd5, AXI_RESP_OKAY, 1'b1);
      @(negedge clk);
      chk("single_valid_s0", W'(s_rvalid), 1);
      chk("single_rready_s0", W'(m_rready), 0);
      @(negedge clk);
      chk("single_rready_s1", W'(m_rready), 1);
      chk("single_last_s1", W'(s_rlast), 1);
      drain();

      // Back-to-back burst: 8 contiguous narrow beats.
      fork
         begin
            for (int b = 0; b < 4; b++)
               drive_r(rnd_wide(), 8'(8'h10 + b), AXI_RESP_OKAY, b == 3);
         end
         begin
            wait_rvalid();
            for (int n = 0; n < 8; n++) begin
               @(negedge clk);
               chk("burst_no_bubble", W'(s_rvalid), 1);
            end
         end
      join
      drain();

      // Backpressure on beat 1 with beat 2 waiting.
      s_rready = 0;
      fork
         begin
            drive_r(rnd_wide(), 8'h21, AXI_RESP_OKAY, 1'b0);
            drive_r(rnd_wide(), 8'h22, AXI_RESP_OKAY, 1'b1);
         end
         begin
            wait_rvalid();
            s_rready = 1;
            @(posedge clk); #1;
            s_rready = 0;
            @(negedge clk);
            chk("bp_no_accept_1", W'(m_rready), 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_no_accept_2", W'(m_rready), 0);
            @(posedge clk); #1;
            s_rready = 1;
            @(negedge clk);
            chk("bp_accept_final", W'(m_rready), 1);
         end
      join
      drain();

      // SLVERR replicated on both slices, then OKAY.
      drive_r(rnd_wide(), 8'h33, AXI_RESP_SLVERR, 1'b0);
      drive_r(rnd_wide(), 8'h34, AXI_RESP_OKAY, 1'b1);
      drain();

      // Async reset between slice 0 and slice 1.
      drive_r(rnd_wide(), 8'h44, AXI_RESP_OKAY, 1'b1);
      @(posedge clk); #1;
      s_rready = 0;
      #2 rst_n = 0;
      #1;
      chk("arst_rvalid", W'(s_rvalid), 0);
      chk("arst_rdata", s_rdata, 0);
      chk("arst_m_rready", W'(m_rready), 1);
      rq.delete();
      #3 rst_n = 1;
      @(posedge clk); #1;
      s_rready = 1;
      drive_r(rnd_wide(), 8'h45, AXI_RESP_DECERR, 1'b1);
      drain();

      // B path held for 3 cycles under backpressure.
      s_bready = 0;
      drive_b(8'd3, AXI_RESP_OKAY);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("b_hold_valid", W'(s_bvalid), 1);
         chk("b_full_bready", W'(m_bready), 0);
         chk("b_hold_id", W'(s_bid), 3);
         if (n < 2) begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      drain();

      // Random R and B traffic with random backpressure.
      rr_rand = 1; br_rand = 1;
      fork
         for (int b = 0; b < 60; b++) begin
            drive_r(rnd_wide(), 8'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
         for (int b = 0; b < 40; b++) begin
            drive_b(8'($urandom), 2'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
      join
      rr_rand = 0; br_rand = 0;
      @(posedge clk); #1;
      drain();

      // Ratio-1 instance: zero-latency pass-through.
      for (int n = 0; n < 8; n++) begin
         p_mrv = 1'($urandom); p_mrl = 1'($urandom); p_srr = 1'($urandom);
         p_mrid = 8'($urandom); p_mrs = 2'($urandom);
         p_mrd = {$urandom, $urandom, $urandom, $urandom};
         p_mbv = 1'($urandom); p_sbr = 1'($urandom); p_mbid = 8'($urandom); p_mbs = 2'($urandom);
         #1;
         chk("r1_rvalid", W'(p_srv), W'(p_mrv));
         chk("r1_rready", W'(p_mrr), W'(p_srr));
         chk("r1_rdata", p_srd, p_mrd);
         chk("r1_rid", W'(p_srid), W'(p_mrid));
         chk("r1_rresp", W'(p_srs), W'(p_mrs));
         chk("r1_rlast", W'(p_srl), W'(p_mrl));
         chk("r1_bvalid", W'(p_sbv), W'(p_mbv));
         chk("r1_bready", W'(p_mbr), W'(p_sbr));
         chk("r1_bid", W'(p_sbid), W'(p_mbid));
         chk("r1_bresp", W'(p_sbs), W'(p_mbs));
         #4;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
